// File: rtl/ins_scheduler_pkg.sv
// Shared widths and the instruction field layout for the instruction scheduler.
// GLOBAL_PARAM carries bus widths; INS_CONST carries opcode/barrier positions and FSM states.
package GLOBAL_PARAM;
    localparam int INST_W = 16;

    // Bits needed to encode n distinct values (0 .. n-1).
    function automatic int bw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

package INS_CONST;
    import GLOBAL_PARAM::*;

    localparam int OP_W    = 4;
    localparam int OP_MSB  = INST_W - 1;
    localparam int BAR_BIT = INST_W - 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_ISSUE   = 2'd2,
        S_BARRIER = 2'd3
    } sched_state_e;
endpackage

// File: rtl/ins_scheduler_if.sv
// Host instruction stream plus per-unit issue/completion signals of the scheduler.
interface ins_scheduler_if #(
    parameter int UNIT_NUM = 3
);
    import GLOBAL_PARAM::*;

    logic                ins_valid;
    logic                ins_ready;
    logic [INST_W-1:0]   ins;
    logic [UNIT_NUM-1:0] unit_ins_valid;
    logic [UNIT_NUM-1:0] unit_ins_ready;
    logic [INST_W-1:0]   unit_ins;
    logic [UNIT_NUM-1:0] unit_done;

    modport master (
        output ins_valid, ins, unit_ins_ready, unit_done,
        input  ins_ready, unit_ins_valid, unit_ins
    );

    modport slave (
        input  ins_valid, ins, unit_ins_ready, unit_done,
        output ins_ready, unit_ins_valid, unit_ins
    );
endinterface

// File: rtl/ins_fifo.sv
// Instruction queue: power-of-two depth, pointers wrap naturally, occupancy exported.
module ins_fifo import GLOBAL_PARAM::*; #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [bw(DEPTH+1)-1:0]   count
);
    localparam int AW = bw(DEPTH);
    localparam int CW = bw(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (rst && do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/ins_scheduler.sv
// Instruction scheduler: queues host instructions and issues each to its target unit,
// honouring per-unit outstanding limits and barrier instructions.
//
//   state     | meaning
//   S_IDLE    | queue empty, nothing held
//   S_LOAD    | pop queue head into issue register (illegal opcodes dropped here)
//   S_ISSUE   | drive unit_ins_valid for held instruction until handshake
//   S_BARRIER | held barrier instruction waits for all units to drain
module ins_scheduler import GLOBAL_PARAM::*; import INS_CONST::*; #(
    parameter int UNIT_NUM   = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int OUTST_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    ins_scheduler_if.slave                bus,
    output logic                          idle,
    output logic [bw(FIFO_DEPTH+1)-1:0]   fifo_count,
    output logic [1:0]                    err
);
    localparam int CW = bw(FIFO_DEPTH + 1);
    localparam int OW = bw(OUTST_MAX + 1);

    sched_state_e        state_q, state_d;
    logic [INST_W-1:0]   issue_q, issue_d;
    logic [OW-1:0]       outst_q [UNIT_NUM];
    logic [OW-1:0]       outst_d [UNIT_NUM];
    logic [1:0]          err_q, err_d;

    logic                ins_ready_w;
    logic                push, pop;
    logic                fifo_full, fifo_empty;
    logic [INST_W-1:0]   fifo_dout;
    logic [CW-1:0]       fifo_cnt;

    logic [OP_W-1:0]     head_op, issue_op;
    logic                head_bar, head_legal;
    logic [UNIT_NUM-1:0] unit_valid, hs_vec;
    logic                hs, illegal, underflow;
    logic                all_zero_q, all_zero_d;

    assign ins_ready_w = rst && !fifo_full;
    assign push        = bus.ins_valid && ins_ready_w;

    ins_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (INST_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.ins),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign head_op    = fifo_dout[OP_MSB -: OP_W];
    assign head_bar   = fifo_dout[BAR_BIT];
    assign head_legal = (int'(head_op) < UNIT_NUM);
    assign issue_op   = issue_q[OP_MSB -: OP_W];

    // Valid only ever targets the held opcode, so at most one bit can be set.
    always_comb begin
        unit_valid = '0;
        for (int u = 0; u < UNIT_NUM; u++) begin
            if (rst && state_q == S_ISSUE && int'(issue_op) == u &&
                int'(outst_q[u]) < OUTST_MAX)
                unit_valid[u] = 1'b1;
        end
    end

    assign hs_vec = unit_valid & bus.unit_ins_ready;
    assign hs     = |hs_vec;

    always_comb begin
        outst_d    = outst_q;
        underflow  = 1'b0;
        all_zero_d = 1'b1;
        all_zero_q = 1'b1;
        for (int u = 0; u < UNIT_NUM; u++) begin
            if (hs_vec[u] && !bus.unit_done[u]) begin
                outst_d[u] = outst_q[u] + 1'b1;
            end else if (!hs_vec[u] && bus.unit_done[u]) begin
                if (outst_q[u] == '0) underflow  = 1'b1;
                else                  outst_d[u] = outst_q[u] - 1'b1;
            end
            if (outst_d[u] != '0) all_zero_d = 1'b0;
            if (outst_q[u] != '0) all_zero_q = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        issue_d = issue_q;
        pop     = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty || push) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (fifo_empty) begin
                    state_d = S_IDLE;
                end else begin
                    pop = 1'b1;
                    if (!head_legal) begin
                        illegal = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        issue_d = fifo_dout;
                        state_d = head_bar ? S_BARRIER : S_ISSUE;
                    end
                end
            end
            // Looking at next-cycle counts lets issue start right after the last done.
            S_BARRIER: begin
                if (all_zero_d) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (hs) state_d = fifo_empty ? S_IDLE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_d = err_q | {underflow, illegal};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            issue_q <= '0;
            outst_q <= '{default: '0};
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            outst_q <= outst_d;
            err_q   <= err_d;
        end
    end

    assign bus.ins_ready      = ins_ready_w;
    assign bus.unit_ins_valid = unit_valid;
    assign bus.unit_ins       = rst ? issue_q : '0;
    assign idle               = !rst || (state_q == S_IDLE && fifo_empty && all_zero_q);
    assign fifo_count         = fifo_cnt;
    assign err                = err_q;
endmodule

// File: tb/tb_ins_scheduler.sv
// Directed bench for ins_scheduler: latency, backpressure, outstanding limit,
// barrier, illegal opcode, done underflow and mid-run reset.
module tb_ins_scheduler;
    import GLOBAL_PARAM::*;

    logic        clk;
    logic        rst;
    logic        idle;
    logic [3:0]  fifo_count;
    logic [1:0]  err;
    int          total;
    int          bad;
    int          n;
    logic [INST_W-1:0] q [9];
    logic [INST_W-1:0] a, b, c;

    ins_scheduler_if #(.UNIT_NUM(3)) bus();

    ins_scheduler #(
        .UNIT_NUM   (3),
        .FIFO_DEPTH (8),
        .OUTST_MAX  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .idle       (idle),
        .fifo_count (fifo_count),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [INST_W-1:0] d);
        bus.ins_valid = 1'b1;
        bus.ins       = d;
        tick();
        bus.ins_valid = 1'b0;
    endtask

    function automatic logic [INST_W-1:0] mk(input int op, input bit bar, input int pl);
        logic [3:0]  o;
        logic [10:0] p;
        o = op[3:0];
        p = pl[10:0];
        return {o, bar, p};
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.ins_valid      = 1'b0;
        bus.ins            = '0;
        bus.unit_ins_ready = 3'b111;
        bus.unit_done      = 3'b000;
        @(negedge clk);
        repeat (2) tick();
        chk("rst_valid", 32'(bus.unit_ins_valid), 0);
        chk("rst_ready", 32'(bus.ins_ready), 0);
        chk("rst_uins",  32'(bus.unit_ins), 0);
        chk("rst_idle",  32'(idle), 1);
        chk("rst_cnt",   32'(fifo_count), 0);
        chk("rst_err",   32'(err), 0);
        rst = 1'b1;
        tick();
        chk("rel_ready", 32'(bus.ins_ready), 1);

        // minimum latency
        a = mk(0, 0, 'h123);
        push(a);
        chk("t1_c1_valid", 32'(bus.unit_ins_valid), 0);
        tick();
        chk("t1_c2_valid", 32'(bus.unit_ins_valid), 1);
        chk("t1_data",     32'(bus.unit_ins), 32'(a));
        tick();
        chk("t1_busy", 32'(idle), 0);
        bus.unit_done = 3'b001;
        tick();
        bus.unit_done = 3'b000;
        chk("t1_idle", 32'(idle), 1);

        // backpressure and in-order drain
        bus.unit_ins_ready = 3'b000;
        for (int k = 0; k < 9; k++) q[k] = mk(k % 3, 0, 'h200 + k);
        for (int k = 0; k < 9; k++) push(q[k]);
        chk("t2_cnt",   32'(fifo_count), 8);
        chk("t2_ready", 32'(bus.ins_ready), 0);
        chk("t2_hold",  32'(bus.unit_ins_valid), 1);
        bus.unit_ins_ready = 3'b111;
        n = 0;
        for (int cyc = 0; cyc < 60 && n < 9; cyc++) begin
            if (|(bus.unit_ins_valid & bus.unit_ins_ready)) begin
                chk("t2_onehot", 32'($countones(bus.unit_ins_valid)), 1);
                chk("t2_order", 32'(bus.unit_ins), 32'(q[n]));
                n++;
            end
            tick();
        end
        chk("t2_drained", 32'(n), 9);
        bus.unit_done = 3'b111;
        repeat (3) tick();
        bus.unit_done = 3'b000;
        chk("t2_idle", 32'(idle), 1);

        // outstanding limit on unit 1
        for (int k = 0; k < 5; k++) q[k] = mk(1, 0, 'h300 + k);
        for (int k = 0; k < 5; k++) push(q[k]);
        repeat (15) tick();
        chk("t3_block", 32'(bus.unit_ins_valid), 0);
        chk("t3_held",  32'(bus.unit_ins), 32'(q[4]));
        chk("t3_cnt",   32'(fifo_count), 0);
        bus.unit_done = 3'b010;
        tick();
        bus.unit_done = 3'b000;
        chk("t3_resume", 32'(bus.unit_ins_valid), 2);
        // first of these dones coincides with the 5th handshake
        bus.unit_done = 3'b010;
        repeat (4) tick();
        bus.unit_done = 3'b000;
        chk("t3_idle", 32'(idle), 1);

        // barrier waits for units 0 and 2
        a = mk(0, 0, 'h400);
        c = mk(2, 0, 'h402);
        b = mk(1, 1, 'h401);
        push(a);
        push(c);
        push(b);
        repeat (10) tick();
        chk("t4_wait",  32'(bus.unit_ins_valid), 0);
        chk("t4_held",  32'(bus.unit_ins), 32'(b));
        bus.unit_done = 3'b001;
        tick();
        bus.unit_done = 3'b000;
        chk("t4_wait2", 32'(bus.unit_ins_valid), 0);
        bus.unit_done = 3'b100;
        tick();
        bus.unit_done = 3'b000;
        chk("t4_go",   32'(bus.unit_ins_valid), 2);
        chk("t4_data", 32'(bus.unit_ins), 32'(b));
        tick();
        bus.unit_done = 3'b010;
        tick();
        bus.unit_done = 3'b000;
        chk("t4_idle", 32'(idle), 1);

        // illegal opcode dropped
        push(mk(5, 0, 'h555));
        repeat (4) tick();
        chk("t5_none", 32'(bus.unit_ins_valid), 0);
        chk("t5_err",  32'(err), 1);
        chk("t5_cnt",  32'(fifo_count), 0);
        c = mk(2, 0, 'h502);
        push(c);
        tick();
        chk("t5_valid", 32'(bus.unit_ins_valid), 4);
        chk("t5_data",  32'(bus.unit_ins), 32'(c));
        tick();
        bus.unit_done = 3'b100;
        tick();
        bus.unit_done = 3'b000;

        // done underflow
        bus.unit_done = 3'b100;
        tick();
        bus.unit_done = 3'b000;
        chk("t6_err",  32'(err), 3);
        chk("t6_idle", 32'(idle), 1);
        push(mk(2, 0, 'h602));
        tick();
        chk("t6_issue", 32'(bus.unit_ins_valid), 4);
        tick();
        bus.unit_done = 3'b100;
        tick();
        bus.unit_done = 3'b000;

        // reset with work queued
        bus.unit_ins_ready = 3'b000;
        for (int k = 0; k < 4; k++) push(mk(0, 0, 'h700 + k));
        chk("t7_cnt",  32'(fifo_count), 3);
        chk("t7_hold", 32'(bus.unit_ins_valid), 1);
        bus.unit_ins_ready = 3'b111;
        rst = 1'b0;
        tick();
        chk("t7_rvalid", 32'(bus.unit_ins_valid), 0);
        chk("t7_ridle",  32'(idle), 1);
        chk("t7_rcnt",   32'(fifo_count), 0);
        chk("t7_rerr",   32'(err), 0);
        rst = 1'b1;
        tick();
        chk("t7_valid", 32'(bus.unit_ins_valid), 0);
        chk("t7_cnt2",  32'(fifo_count), 0);
        chk("t7_idle",  32'(idle), 1);
        repeat (3) tick();
        chk("t7_quiet", 32'(bus.unit_ins_valid), 0);
        chk("t7_idle2", 32'(idle), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
